// File: rtl/bus_requester.sv
// Per-CPU master for the shared snooping bus: takes one coherence command from
// the L1, arbitrates for the bus, issues it, and returns the response.
module bus_requester #(
    parameter int ADDR_W   = 32,
    parameter int LINE_W   = 256,
    parameter int CPU_ID   = 0,
    parameter int NUM_CPUS = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_req_valid,
    output logic                cpu_req_ready,
    input  logic [1:0]          cpu_req_cmd,
    input  logic [ADDR_W-1:0]   cpu_req_addr,
    input  logic [LINE_W-1:0]   cpu_req_wdata,
    output logic                cpu_resp_valid,
    output logic [LINE_W-1:0]   cpu_resp_data,
    output logic                cpu_resp_shared,
    output logic                cpu_resp_err,
    output logic                arb_req,
    input  logic                arb_gnt,
    output logic                arb_busy,
    input  logic                snoop_inval,
    input  logic [ADDR_W-1:0]   snoop_addr,
    output logic                bus_valid,
    output logic [1:0]          bus_cmd,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [LINE_W-1:0]   bus_wdata,
    output logic [NUM_CPUS-1:0] bus_src,
    input  logic                bus_done,
    input  logic [LINE_W-1:0]   bus_rdata,
    input  logic                bus_shared
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] CMD_RD   = 2'd0;
    localparam logic [1:0] CMD_RDX  = 2'd1;
    localparam logic [1:0] CMD_UPGR = 2'd2;

    localparam logic [NUM_CPUS-1:0] SRC_ONEHOT = {{(NUM_CPUS-1){1'b0}}, 1'b1} << CPU_ID;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t state, state_next;

    logic [1:0]        cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] rdata_q;
    logic              shared_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt;

    logic accept;
    logic upgrade_hit;
    logic done_hit;
    logic timeout_hit;

    assign accept      = (state == IDLE) && cpu_req_valid;
    // Another CPU invalidating our line while we wait to upgrade means our copy is
    // gone, so we must fetch the whole line instead.
    assign upgrade_hit = (state == REQ) && (cmd_q == CMD_UPGR) && snoop_inval &&
                         (snoop_addr == addr_q);
    assign done_hit    = (state == WAIT) && bus_done;
    assign timeout_hit = (state == WAIT) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        cpu_req_ready   = 1'b0;
        cpu_resp_valid  = 1'b0;
        cpu_resp_data   = '0;
        cpu_resp_shared = 1'b0;
        cpu_resp_err    = 1'b0;
        arb_req         = 1'b0;
        arb_busy        = 1'b0;
        bus_valid       = 1'b0;
        bus_src         = '0;
        case (state)
            IDLE: begin
                cpu_req_ready = 1'b1;
                if (accept) state_next = REQ;
            end
            REQ: begin
                // busy must stay low here or the arbiter would never grant us
                arb_req = 1'b1;
                if (arb_gnt) state_next = ISSUE;
            end
            ISSUE: begin
                bus_valid  = 1'b1;
                bus_src    = SRC_ONEHOT;
                arb_busy   = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                arb_busy = 1'b1;
                if (done_hit || timeout_hit) state_next = RESP;
            end
            RESP: begin
                cpu_resp_valid  = 1'b1;
                cpu_resp_data   = rdata_q;
                cpu_resp_shared = shared_q;
                cpu_resp_err    = err_q;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus_cmd   = cmd_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cmd_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            shared_q <= 1'b0;
            err_q    <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cmd_q   <= cpu_req_cmd;
                        addr_q  <= cpu_req_addr;
                        wdata_q <= cpu_req_wdata;
                    end
                end
                REQ: begin
                    if (upgrade_hit) cmd_q <= CMD_RDX;
                end
                ISSUE: begin
                    cnt <= '0;
                end
                WAIT: begin
                    // a completion landing on the timeout cycle still counts as success
                    if (bus_done) begin
                        rdata_q  <= (cmd_q == CMD_RD || cmd_q == CMD_RDX) ? bus_rdata : '0;
                        shared_q <= bus_shared;
                        err_q    <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata_q  <= '0;
                        shared_q <= 1'b0;
                        err_q    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_requester.sv
// Directed bench for bus_requester: hand-computed cycle-by-cycle expectations
// for each scenario, driven and sampled on the falling clock edge.
module tb_bus_requester;

    localparam int ADDR_W   = 32;
    localparam int LINE_W   = 256;
    localparam int NUM_CPUS = 4;
    localparam int CPU_ID   = 2;
    localparam int TIMEOUT  = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                cpu_req_valid;
    logic                cpu_req_ready;
    logic [1:0]          cpu_req_cmd;
    logic [ADDR_W-1:0]   cpu_req_addr;
    logic [LINE_W-1:0]   cpu_req_wdata;
    logic                cpu_resp_valid;
    logic [LINE_W-1:0]   cpu_resp_data;
    logic                cpu_resp_shared;
    logic                cpu_resp_err;
    logic                arb_req;
    logic                arb_gnt;
    logic                arb_busy;
    logic                snoop_inval;
    logic [ADDR_W-1:0]   snoop_addr;
    logic                bus_valid;
    logic [1:0]          bus_cmd;
    logic [ADDR_W-1:0]   bus_addr;
    logic [LINE_W-1:0]   bus_wdata;
    logic [NUM_CPUS-1:0] bus_src;
    logic                bus_done;
    logic [LINE_W-1:0]   bus_rdata;
    logic                bus_shared;

    int checks = 0;
    int errors = 0;

    localparam logic [LINE_W-1:0] PAT_A5 = {32{8'hA5}};
    localparam logic [LINE_W-1:0] PAT_5A = {32{8'h5A}};
    localparam logic [LINE_W-1:0] PAT_WB = {8{32'hDEAD_BEEF}};

    bus_requester #(
        .ADDR_W(ADDR_W), .LINE_W(LINE_W), .CPU_ID(CPU_ID),
        .NUM_CPUS(NUM_CPUS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_cmd(cpu_req_cmd), .cpu_req_addr(cpu_req_addr),
        .cpu_req_wdata(cpu_req_wdata),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_data(cpu_resp_data),
        .cpu_resp_shared(cpu_resp_shared), .cpu_resp_err(cpu_resp_err),
        .arb_req(arb_req), .arb_gnt(arb_gnt), .arb_busy(arb_busy),
        .snoop_inval(snoop_inval), .snoop_addr(snoop_addr),
        .bus_valid(bus_valid), .bus_cmd(bus_cmd), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_src(bus_src),
        .bus_done(bus_done), .bus_rdata(bus_rdata), .bus_shared(bus_shared)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Presents one command for a single cycle; returns in the first REQ cycle.
    task automatic present(input logic [1:0] cmd, input logic [ADDR_W-1:0] addr,
                           input logic [LINE_W-1:0] wd);
        cpu_req_valid = 1'b1;
        cpu_req_cmd   = cmd;
        cpu_req_addr  = addr;
        cpu_req_wdata = wd;
        step();
        cpu_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        checks++; if (cpu_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cpu_req_ready); end
        checks++; if ({arb_req, arb_busy, bus_valid, cpu_resp_valid, cpu_resp_shared, cpu_resp_err, bus_cmd, bus_src} !== 10'd0) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=0", {arb_req, arb_busy, bus_valid, cpu_resp_valid, cpu_resp_shared, cpu_resp_err, bus_cmd, bus_src});
        end
        checks++; if ({bus_addr, bus_wdata, cpu_resp_data} !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", {bus_addr, bus_wdata, cpu_resp_data}); end
    endtask

    task automatic test_basic_read();
        present(2'd0, 32'h40, '0);
        checks++; if ({arb_req, arb_busy, cpu_req_ready} !== 3'b100) begin errors++; $display("FAIL basic_req got=%b exp=100", {arb_req, arb_busy, cpu_req_ready}); end
        arb_gnt = 1'b1;
        step();
        arb_gnt = 1'b0;
        checks++; if ({bus_valid, arb_req, arb_busy} !== 3'b101) begin errors++; $display("FAIL basic_issue_ctrl got=%b exp=101", {bus_valid, arb_req, arb_busy}); end
        checks++; if (bus_cmd !== 2'd0 || bus_addr !== 32'h40) begin errors++; $display("FAIL basic_issue_cmd got=%0d/%h exp=0/40", bus_cmd, bus_addr); end
        checks++; if (bus_src !== 4'b0100) begin errors++; $display("FAIL basic_src got=%b exp=0100", bus_src); end
        step();
        bus_done = 1'b1; bus_rdata = PAT_A5; bus_shared = 1'b1;
        checks++; if ({bus_valid, arb_busy, cpu_resp_valid} !== 3'b010) begin errors++; $display("FAIL basic_wait got=%b exp=010", {bus_valid, arb_busy, cpu_resp_valid}); end
        step();
        bus_done = 1'b0; bus_rdata = '0; bus_shared = 1'b0;
        checks++; if ({cpu_resp_valid, cpu_resp_shared, cpu_resp_err, arb_busy} !== 4'b1100) begin errors++; $display("FAIL basic_resp got=%b exp=1100", {cpu_resp_valid, cpu_resp_shared, cpu_resp_err, arb_busy}); end
        checks++; if (cpu_resp_data !== PAT_A5) begin errors++; $display("FAIL basic_data got=%h exp=%h", cpu_resp_data, PAT_A5); end
        step();
        checks++; if ({cpu_resp_valid, cpu_req_ready} !== 2'b01) begin errors++; $display("FAIL basic_idle got=%b exp=01", {cpu_resp_valid, cpu_req_ready}); end
    endtask

    task automatic test_grant_delay();
        present(2'd1, 32'h1000, '0);
        for (int i = 0; i < 4; i++) begin
            checks++; if ({arb_req, arb_busy, bus_valid} !== 3'b100) begin errors++; $display("FAIL gnt_delay_req%0d got=%b exp=100", i, {arb_req, arb_busy, bus_valid}); end
            if (i == 3) arb_gnt = 1'b1;
            step();
        end
        arb_gnt = 1'b0;
        checks++; if ({bus_valid, arb_req} !== 2'b10) begin errors++; $display("FAIL gnt_delay_issue got=%b exp=10", {bus_valid, arb_req}); end
        step();
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL gnt_delay_one_cycle got=%b exp=0", bus_valid); end
        bus_done = 1'b1; bus_rdata = PAT_5A; bus_shared = 1'b0;
        step();
        bus_done = 1'b0;
        checks++; if (cpu_resp_valid !== 1'b1 || cpu_resp_data !== PAT_5A || cpu_resp_shared !== 1'b0) begin
            errors++; $display("FAIL gnt_delay_resp got=%b/%h exp=1/%h", cpu_resp_valid, cpu_resp_data, PAT_5A);
        end
        step();
    endtask

    task automatic test_upgrade();
        logic [ADDR_W-1:0] saddr [2];
        logic [1:0]        exp_cmd [2];
        logic [LINE_W-1:0] exp_data [2];
        saddr[0] = 32'h80; exp_cmd[0] = 2'd1; exp_data[0] = PAT_A5;
        saddr[1] = 32'hC0; exp_cmd[1] = 2'd2; exp_data[1] = '0;
        for (int i = 0; i < 2; i++) begin
            present(2'd2, 32'h80, '0);
            snoop_inval = 1'b1; snoop_addr = saddr[i]; arb_gnt = 1'b1;
            step();
            snoop_inval = 1'b0; snoop_addr = '0; arb_gnt = 1'b0;
            checks++; if (bus_valid !== 1'b1 || bus_cmd !== exp_cmd[i]) begin errors++; $display("FAIL upgrade_cmd%0d got=%b/%0d exp=1/%0d", i, bus_valid, bus_cmd, exp_cmd[i]); end
            step();
            bus_done = 1'b1; bus_rdata = PAT_A5; bus_shared = 1'b1;
            step();
            bus_done = 1'b0; bus_rdata = '0; bus_shared = 1'b0;
            checks++; if (cpu_resp_valid !== 1'b1 || cpu_resp_shared !== 1'b1 || cpu_resp_data !== exp_data[i]) begin
                errors++; $display("FAIL upgrade_resp%0d got=%b/%b/%h exp=1/1/%h", i, cpu_resp_valid, cpu_resp_shared, cpu_resp_data, exp_data[i]);
            end
            step();
        end
    endtask

    task automatic test_flush();
        present(2'd3, 32'h2C0, PAT_WB);
        arb_gnt = 1'b1;
        step();
        arb_gnt = 1'b0;
        checks++; if (bus_cmd !== 2'd3 || bus_wdata !== PAT_WB || bus_addr !== 32'h2C0) begin
            errors++; $display("FAIL flush_issue got=%0d/%h/%h exp=3/2c0/%h", bus_cmd, bus_addr, bus_wdata, PAT_WB);
        end
        step();
        bus_done = 1'b1; bus_rdata = PAT_A5; bus_shared = 1'b0;
        step();
        bus_done = 1'b0; bus_rdata = '0;
        checks++; if (cpu_resp_valid !== 1'b1 || cpu_resp_data !== '0) begin errors++; $display("FAIL flush_resp got=%b/%h exp=1/0", cpu_resp_valid, cpu_resp_data); end
        step();
    endtask

    task automatic test_timeout();
        present(2'd0, 32'h300, '0);
        arb_gnt = 1'b1;
        step();
        arb_gnt = 1'b0;
        step();
        for (int i = 0; i < TIMEOUT; i++) begin
            checks++; if ({cpu_resp_valid, arb_busy} !== 2'b01) begin errors++; $display("FAIL timeout_wait%0d got=%b exp=01", i, {cpu_resp_valid, arb_busy}); end
            step();
        end
        checks++; if ({cpu_resp_valid, cpu_resp_err, arb_busy} !== 3'b110 || cpu_resp_data !== '0) begin
            errors++; $display("FAIL timeout_resp got=%b/%h exp=110/0", {cpu_resp_valid, cpu_resp_err, arb_busy}, cpu_resp_data);
        end
        step();
        checks++; if (cpu_req_ready !== 1'b1) begin errors++; $display("FAIL timeout_idle got=%b exp=1", cpu_req_ready); end
        present(2'd0, 32'h44, '0);
        arb_gnt = 1'b1;
        step();
        arb_gnt = 1'b0;
        step();
        bus_done = 1'b1; bus_rdata = 256'h1234; bus_shared = 1'b0;
        step();
        bus_done = 1'b0; bus_rdata = '0;
        checks++; if ({cpu_resp_valid, cpu_resp_err} !== 2'b10 || cpu_resp_data !== 256'h1234) begin
            errors++; $display("FAIL timeout_next got=%b/%h exp=10/1234", {cpu_resp_valid, cpu_resp_err}, cpu_resp_data);
        end
        step();
    endtask

    task automatic test_done_at_timeout();
        present(2'd1, 32'h500, '0);
        arb_gnt = 1'b1;
        step();
        arb_gnt = 1'b0;
        step();
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        bus_done = 1'b1; bus_rdata = PAT_5A; bus_shared = 1'b1;
        step();
        bus_done = 1'b0; bus_rdata = '0; bus_shared = 1'b0;
        checks++; if ({cpu_resp_valid, cpu_resp_err, cpu_resp_shared} !== 3'b101 || cpu_resp_data !== PAT_5A) begin
            errors++; $display("FAIL done_wins got=%b/%h exp=101/%h", {cpu_resp_valid, cpu_resp_err, cpu_resp_shared}, cpu_resp_data, PAT_5A);
        end
        step();
    endtask

    task automatic test_reset_mid();
        present(2'd3, 32'h600, PAT_WB);
        arb_gnt = 1'b1;
        step();
        arb_gnt = 1'b0;
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        checks++; if ({arb_req, arb_busy, bus_valid, cpu_resp_valid, cpu_resp_err, bus_cmd, bus_src} !== 9'd0 || cpu_req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_ctrl got=%b ready=%b exp=0 ready=1", {arb_req, arb_busy, bus_valid, cpu_resp_valid, cpu_resp_err, bus_cmd, bus_src}, cpu_req_ready);
        end
        checks++; if ({bus_addr, bus_wdata} !== '0) begin errors++; $display("FAIL rst_mid_data got=%h exp=0", {bus_addr, bus_wdata}); end
        bus_done = 1'b1; bus_rdata = PAT_A5;
        step();
        bus_done = 1'b0; bus_rdata = '0;
        checks++; if ({cpu_resp_valid, cpu_req_ready, arb_busy} !== 3'b010) begin errors++; $display("FAIL rst_mid_late_done got=%b exp=010", {cpu_resp_valid, cpu_req_ready, arb_busy}); end
        step();
        checks++; if (cpu_resp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_no_resp got=%b exp=0", cpu_resp_valid); end
    endtask

    task automatic test_stray();
        arb_gnt = 1'b1;
        step();
        step();
        arb_gnt = 1'b0;
        checks++; if ({arb_req, bus_valid, cpu_req_ready} !== 3'b001) begin errors++; $display("FAIL stray_gnt got=%b exp=001", {arb_req, bus_valid, cpu_req_ready}); end
        present(2'd0, 32'h200, '0);
        arb_gnt = 1'b1;
        step();
        arb_gnt = 1'b0;
        bus_done = 1'b1; bus_rdata = PAT_WB;
        step();
        bus_done = 1'b0; bus_rdata = '0;
        checks++; if ({cpu_resp_valid, arb_busy} !== 2'b01) begin errors++; $display("FAIL stray_done_issue got=%b exp=01", {cpu_resp_valid, arb_busy}); end
        cpu_req_valid = 1'b1; cpu_req_cmd = 2'd3; cpu_req_addr = 32'h300;
        step();
        checks++; if (bus_addr !== 32'h200 || bus_cmd !== 2'd0 || cpu_req_ready !== 1'b0) begin
            errors++; $display("FAIL stray_held_req got=%h/%0d/%b exp=200/0/0", bus_addr, bus_cmd, cpu_req_ready);
        end
        bus_done = 1'b1; bus_rdata = PAT_5A; bus_shared = 1'b1;
        step();
        cpu_req_valid = 1'b0;
        bus_done = 1'b0; bus_rdata = '0; bus_shared = 1'b0;
        checks++; if (cpu_resp_valid !== 1'b1 || cpu_resp_data !== PAT_5A || bus_addr !== 32'h200) begin
            errors++; $display("FAIL stray_resp got=%b/%h/%h exp=1/%h/200", cpu_resp_valid, cpu_resp_data, bus_addr, PAT_5A);
        end
        step();
        step();
        checks++; if ({arb_req, cpu_req_ready} !== 2'b01) begin errors++; $display("FAIL stray_no_relatch got=%b exp=01", {arb_req, cpu_req_ready}); end
    endtask

    initial begin
        rst = 1'b0;
        cpu_req_valid = 1'b0; cpu_req_cmd = '0; cpu_req_addr = '0; cpu_req_wdata = '0;
        arb_gnt = 1'b0; snoop_inval = 1'b0; snoop_addr = '0;
        bus_done = 1'b0; bus_rdata = '0; bus_shared = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_read();
        test_grant_delay();
        test_upgrade();
        test_flush();
        test_timeout();
        test_done_at_timeout();
        test_reset_mid();
        test_stray();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
